// File: rtl/sys_defs.sv
// Shared bus definitions for the processor-side memory initiator.
package sys_defs;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } BUS_COMMAND;

   typedef logic [3:0] MEM_TAG;

   typedef enum logic {
      OWN_ICACHE = 1'b0,
      OWN_DCACHE = 1'b1
   } REQ_OWNER;

   typedef struct packed {
      logic     valid;
      REQ_OWNER owner;
   } TAG_ENTRY;

   // Tag 0 is reserved for "not accepted / no data", so tags 1..15 are usable.
   localparam int NUM_MEM_TAGS      = 15;
   localparam int DEF_STARVE_LIMIT  = 4;

endpackage

// File: rtl/mem_tag_table.sv
// Outstanding-load table: one {valid, owner} entry per memory tag.
// Allocates on accepted loads, looks up and clears on returning tags,
// keeps the outstanding count and a sticky flag for unexpected returns.
module mem_tag_table
   import sys_defs::*;
#(
   parameter int NUM_TAGS = NUM_MEM_TAGS
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       alloc_i,
   input  logic [3:0] alloc_tag_i,
   input  logic       alloc_owner_i,
   input  logic [3:0] ret_tag_i,
   output logic       ret_valid_o,
   output logic       ret_owner_o,
   output logic [3:0] count_o,
   output logic       spurious_o
);

   logic [NUM_TAGS:1] hit_vec;
   logic [NUM_TAGS:1] valid_vec;
   logic [NUM_TAGS:1] owner_vec;
   logic [NUM_TAGS:1] valid_d_vec;

   logic [3:0] count_q, count_d;
   logic       spurious_q, spurious_d;
   logic       ret_hit;

   genvar gi;
   generate
      for (gi = 1; gi <= NUM_TAGS; gi++) begin : g_entry
         TAG_ENTRY entry_q, entry_d;
         logic     ret_match;
         logic     alloc_match;

         assign ret_match   = (ret_tag_i == MEM_TAG'(gi));
         assign alloc_match = alloc_i && (alloc_tag_i == MEM_TAG'(gi));

         // A fresh allocation beats a same-cycle return; a return clears the entry.
         always_comb begin
            entry_d = entry_q;
            if (alloc_match) begin
               entry_d.valid = 1'b1;
               entry_d.owner = REQ_OWNER'(alloc_owner_i);
            end else if (ret_match) begin
               entry_d = '0;
            end
         end

         // Per-tag entry storage.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               entry_q <= '0;
            end else begin
               entry_q <= entry_d;
            end
         end

         assign hit_vec[gi]     = ret_match;
         assign valid_vec[gi]   = entry_q.valid;
         assign owner_vec[gi]   = (entry_q.owner == OWN_DCACHE);
         assign valid_d_vec[gi] = entry_d.valid;
      end
   endgenerate

   // Lookup uses the current table state, so a same-cycle realloc still routes to the old owner.
   assign ret_hit     = |(hit_vec & valid_vec);
   assign ret_valid_o = ret_hit;
   assign ret_owner_o = |(hit_vec & valid_vec & owner_vec);

   // Outstanding count is the population of valid entries after this cycle's updates.
   always_comb begin
      count_d = '0;
      for (int i = 1; i <= NUM_TAGS; i++) begin
         count_d = count_d + {3'b000, valid_d_vec[i]};
      end
      spurious_d = spurious_q | ((ret_tag_i != 4'd0) && !ret_hit);
   end

   // Count and sticky spurious flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q    <= '0;
         spurious_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         spurious_q <= spurious_d;
      end
   end

   assign count_o    = count_q;
   assign spurious_o = spurious_q;

endmodule

// File: rtl/mem_req_arbiter.sv
// Processor-side initiator for the unified memory bus: arbitrates icache
// and dcache onto proc2mem_*, and routes returning load data by tag.
module mem_req_arbiter
   import sys_defs::*;
#(
   parameter int NUM_TAGS     = NUM_MEM_TAGS,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ic_req_valid,
   input  logic [63:0] ic_req_addr,
   input  logic        dc_req_valid,
   input  logic [1:0]  dc_req_cmd,
   input  logic [63:0] dc_req_addr,
   input  logic [63:0] dc_req_data,
   input  logic [3:0]  mem2proc_response,
   input  logic [63:0] mem2proc_data,
   input  logic [3:0]  mem2proc_tag,
   output logic [1:0]  proc2mem_command,
   output logic [63:0] proc2mem_addr,
   output logic [63:0] proc2mem_data,
   output logic        ic_accepted,
   output logic        dc_accepted,
   output logic        ic_resp_valid,
   output logic        dc_resp_valid,
   output logic [63:0] resp_data,
   output logic [3:0]  inflight_count,
   output logic        spurious_tag
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] starve_q, starve_d;
   logic          starve_full;
   logic          ic_grant, dc_grant;
   logic          bus_accept;
   logic          alloc;
   logic          alloc_owner;
   logic          ret_valid, ret_owner;
   BUS_COMMAND    cmd_d;

   assign starve_full = (starve_q == SW'(STARVE_LIMIT));
   assign bus_accept  = (mem2proc_response != 4'd0);

   // Dcache has priority unless icache has lost STARVE_LIMIT contested rounds in a row.
   always_comb begin
      dc_grant = dc_req_valid && !(ic_req_valid && starve_full);
      ic_grant = ic_req_valid && !dc_grant;
   end

   // Drive the bus from the granted requester only; quiet bus otherwise and during reset.
   always_comb begin
      cmd_d         = BUS_NONE;
      proc2mem_addr = '0;
      proc2mem_data = '0;
      if (!reset) begin
         if (dc_grant) begin
            cmd_d         = BUS_COMMAND'(dc_req_cmd);
            proc2mem_addr = dc_req_addr;
            proc2mem_data = dc_req_data;
         end else if (ic_grant) begin
            cmd_d         = BUS_LOAD;
            proc2mem_addr = ic_req_addr;
         end
      end
   end

   assign proc2mem_command = cmd_d;

   // Acceptance is same-cycle: the responder hands back a nonzero tag.
   always_comb begin
      ic_accepted = !reset && ic_grant && bus_accept;
      dc_accepted = !reset && dc_grant && bus_accept;
      alloc       = ic_accepted ||
                    (dc_accepted && (BUS_COMMAND'(dc_req_cmd) == BUS_LOAD));
      alloc_owner = dc_accepted;
   end

   // Count consecutive contested dcache wins; any icache grant or idle icache restarts it.
   always_comb begin
      starve_d = '0;
      if (ic_req_valid && dc_req_valid && dc_grant) begin
         starve_d = starve_full ? starve_q : starve_q + SW'(1);
      end
   end

   // Starvation counter register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

   mem_tag_table #(
      .NUM_TAGS (NUM_TAGS)
   ) u_tag_table (
      .clock         (clock),
      .reset         (reset),
      .alloc_i       (alloc),
      .alloc_tag_i   (mem2proc_response),
      .alloc_owner_i (alloc_owner),
      .ret_tag_i     (mem2proc_tag),
      .ret_valid_o   (ret_valid),
      .ret_owner_o   (ret_owner),
      .count_o       (inflight_count),
      .spurious_o    (spurious_tag)
   );

   // Route returning data to the tag's recorded owner.
   always_comb begin
      ic_resp_valid = !reset && ret_valid && (ret_owner == OWN_ICACHE);
      dc_resp_valid = !reset && ret_valid && (ret_owner == OWN_DCACHE);
      resp_data     = (ic_resp_valid || dc_resp_valid) ? mem2proc_data : '0;
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: directed scenarios plus random traffic.
module tb_mem_req_arbiter;
   import sys_defs::*;

   localparam int LIMIT = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        ic_req_valid;
   logic [63:0] ic_req_addr;
   logic        dc_req_valid;
   logic [1:0]  dc_req_cmd;
   logic [63:0] dc_req_addr;
   logic [63:0] dc_req_data;
   logic [3:0]  mem2proc_response;
   logic [63:0] mem2proc_data;
   logic [3:0]  mem2proc_tag;
   logic [1:0]  proc2mem_command;
   logic [63:0] proc2mem_addr;
   logic [63:0] proc2mem_data;
   logic        ic_accepted, dc_accepted;
   logic        ic_resp_valid, dc_resp_valid;
   logic [63:0] resp_data;
   logic [3:0]  inflight_count;
   logic        spurious_tag;

   always #5 clock = ~clock;

   mem_req_arbiter dut (
      .clock             (clock),
      .reset             (reset),
      .ic_req_valid      (ic_req_valid),
      .ic_req_addr       (ic_req_addr),
      .dc_req_valid      (dc_req_valid),
      .dc_req_cmd        (dc_req_cmd),
      .dc_req_addr       (dc_req_addr),
      .dc_req_data       (dc_req_data),
      .mem2proc_response (mem2proc_response),
      .mem2proc_data     (mem2proc_data),
      .mem2proc_tag      (mem2proc_tag),
      .proc2mem_command  (proc2mem_command),
      .proc2mem_addr     (proc2mem_addr),
      .proc2mem_data     (proc2mem_data),
      .ic_accepted       (ic_accepted),
      .dc_accepted       (dc_accepted),
      .ic_resp_valid     (ic_resp_valid),
      .dc_resp_valid     (dc_resp_valid),
      .resp_data         (resp_data),
      .inflight_count    (inflight_count),
      .spurious_tag      (spurious_tag)
   );

   typedef struct {
      logic [1:0]  cmd;
      logic [63:0] addr;
      logic [63:0] data;
      logic        ic_acc;
      logic        dc_acc;
      logic        ic_rv;
      logic        dc_rv;
      logic [63:0] rdata;
      logic [3:0]  inflight;
      logic        spur;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   txn   = 0;

   // Reference state: owner per tag (0 none, 1 icache, 2 dcache), dcache win streak, sticky flag.
   int   owner_of [16];
   int   streak;
   bit   spur_m;
   bit   last_ic_acc, last_dc_acc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   function automatic int model_count();
      int n = 0;
      for (int t = 1; t < 16; t++) if (owner_of[t] != 0) n++;
      return n;
   endfunction

   task automatic model_clear();
      for (int t = 0; t < 16; t++) owner_of[t] = 0;
      streak = 0;
      spur_m = 1'b0;
   endtask

   // Drive one cycle of inputs and push what the DUT should present for it.
   task automatic step(input bit icv, input logic [63:0] ica, input bit dcv,
                       input logic [1:0] dcc, input logic [63:0] dca, input logic [63:0] dcd,
                       input logic [3:0] resp, input logic [3:0] rtag, input logic [63:0] rdata);
      exp_t e;
      bit   icw, dcw;
      @(negedge clock);
      ic_req_valid      = icv;
      ic_req_addr       = ica;
      dc_req_valid      = dcv;
      dc_req_cmd        = dcc;
      dc_req_addr       = dca;
      dc_req_data       = dcd;
      mem2proc_response = resp;
      mem2proc_tag      = rtag;
      mem2proc_data     = rdata;

      icw = icv && (!dcv || streak >= LIMIT);
      dcw = dcv && !icw;
      e.cmd      = icw ? 2'd1 : (dcw ? dcc : 2'd0);
      e.addr     = icw ? ica : (dcw ? dca : 64'd0);
      e.data     = dcw ? dcd : 64'd0;
      e.ic_acc   = icw && (resp != 0);
      e.dc_acc   = dcw && (resp != 0);
      e.ic_rv    = (rtag != 0) && (owner_of[rtag] == 1);
      e.dc_rv    = (rtag != 0) && (owner_of[rtag] == 2);
      e.rdata    = rdata;
      e.inflight = 4'(model_count());
      e.spur     = spur_m;
      if (e.cmd != 0 || e.ic_rv || e.dc_rv) exp_q.push_back(e);

      if (rtag != 0) begin
         if (owner_of[rtag] != 0) owner_of[rtag] = 0;
         else                     spur_m = 1'b1;
      end
      if (e.ic_acc)                 owner_of[resp] = 1;
      if (e.dc_acc && dcc == 2'd1)  owner_of[resp] = 2;
      if (icv && dcv && dcw) streak = (streak < LIMIT) ? streak + 1 : streak;
      else                   streak = 0;
      last_ic_acc = e.ic_acc;
      last_dc_acc = e.dc_acc;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Async reset in mid-cycle with the previous inputs still applied.
   task automatic reset_pulse();
      #3;
      reset = 1'b1;
      #1;
      chk("rst_cmd", proc2mem_command, 0);
      chk("rst_addr", proc2mem_addr, 0);
      chk("rst_acc", {ic_accepted, dc_accepted}, 0);
      chk("rst_inflight", inflight_count, 0);
      chk("rst_spur", spurious_tag, 0);
      model_clear();
      @(negedge clock);
      ic_req_valid = 0; dc_req_valid = 0; mem2proc_response = 0; mem2proc_tag = 0;
      reset = 1'b0;
   endtask

   // Monitor: whenever the DUT shows bus or response activity, compare to the next expectation.
   initial begin
      forever begin
         @(negedge clock);
         #2;
         if (reset) continue;
         if (proc2mem_command != 0 || ic_resp_valid || dc_resp_valid) begin
            txn++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected txn %0d: cmd=%0d icv=%0b dcv=%0b want nothing", txn,
                        proc2mem_command, ic_resp_valid, dc_resp_valid);
            end else begin
               mon_e = exp_q.pop_front();
               $display("txn %0d cmd=%0d addr=%0h acc=%0b%0b rv=%0b%0b data=%0h infl=%0d", txn,
                        proc2mem_command, proc2mem_addr, ic_accepted, dc_accepted,
                        ic_resp_valid, dc_resp_valid, resp_data, inflight_count);
               chk("cmd", proc2mem_command, mon_e.cmd);
               chk("addr", proc2mem_addr, mon_e.addr);
               chk("wdata", proc2mem_data, mon_e.data);
               chk("ic_acc", ic_accepted, mon_e.ic_acc);
               chk("dc_acc", dc_accepted, mon_e.dc_acc);
               chk("ic_rv", ic_resp_valid, mon_e.ic_rv);
               chk("dc_rv", dc_resp_valid, mon_e.dc_rv);
               if (mon_e.ic_rv || mon_e.dc_rv) chk("rdata", resp_data, mon_e.rdata);
               chk("inflight", inflight_count, mon_e.inflight);
               chk("spur", spurious_tag, mon_e.spur);
            end
         end
      end
   end

   initial begin
      bit          icp, dcp;
      logic [63:0] ra, da, dd, rd;
      logic [1:0]  dc_cmd;
      logic [3:0]  t, r, rsp;

      model_clear();
      icp = 0; dcp = 0; ra = 0; da = 0; dd = 0; dc_cmd = 1;
      reset = 1'b1;
      ic_req_valid = 1; ic_req_addr = 64'h100; dc_req_valid = 0; dc_req_cmd = 0;
      dc_req_addr = 0; dc_req_data = 0; mem2proc_response = 4'd3;
      mem2proc_tag = 4'd1; mem2proc_data = 64'h1;
      #1;
      chk("init_cmd", proc2mem_command, 0);
      chk("init_acc", ic_accepted, 0);
      chk("init_rv", ic_resp_valid, 0);
      chk("init_inflight", inflight_count, 0);
      chk("init_spur", spurious_tag, 0);
      @(negedge clock);
      ic_req_valid = 0; mem2proc_response = 0; mem2proc_tag = 0;
      reset = 1'b0;

      // Lone icache load, data back eight cycles later.
      step(1, 64'h100, 0, 0, 0, 0, 4'd3, 0, 0);
      repeat (7) idle();
      step(0, 0, 0, 0, 0, 0, 0, 4'd3, 64'hDEAD);
      idle();
      #2 chk("lone_inflight_after", inflight_count, 0);

      // Contested for six cycles: dcache x4, icache, dcache.
      for (int i = 0; i < 6; i++)
         step(1, (i < 5) ? 64'h300 : 64'h340, 1, 2'd2, 64'h400 + 64'(i), 64'h11, 4'd6, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 4'd6, 64'h66);

      // Store allocates nothing; its tag coming back is spurious.
      step(0, 0, 1, 2'd2, 64'h200, 64'h55, 4'd7, 0, 0);
      idle();
      #2 chk("store_inflight", inflight_count, 0);
      step(0, 0, 0, 0, 0, 0, 0, 4'd7, 64'h77);
      idle();
      #2 chk("store_spur", spurious_tag, 1);

      // Tag 5 returns to dcache while icache is accepted on tag 5.
      step(0, 0, 1, 2'd1, 64'h500, 0, 4'd5, 0, 0);
      step(1, 64'h600, 0, 0, 0, 0, 4'd5, 4'd5, 64'hA5);
      step(0, 0, 0, 0, 0, 0, 0, 4'd5, 64'h5A);

      // Reset with two loads outstanding; a stale tag then returns.
      step(1, 64'h800, 0, 0, 0, 0, 4'd1, 0, 0);
      step(0, 0, 1, 2'd1, 64'h900, 0, 4'd2, 0, 0);
      reset_pulse();
      step(0, 0, 0, 0, 0, 0, 0, 4'd1, 64'hBAD);
      idle();
      #2 chk("stale_spur", spurious_tag, 1);

      // Rejected three times, then accepted on tag 9.
      for (int i = 0; i < 3; i++) step(0, 0, 1, 2'd1, 64'h700, 0, 0, 0, 0);
      step(0, 0, 1, 2'd1, 64'h700, 0, 4'd9, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 4'd9, 64'h999);

      // Random traffic with requesters that hold until accepted.
      for (int c = 0; c < 400; c++) begin
         if (!icp && $urandom_range(0, 2) == 0) begin
            icp = 1; ra = {$urandom, $urandom};
         end
         if (!dcp && $urandom_range(0, 2) == 0) begin
            dcp = 1; dc_cmd = ($urandom_range(0, 3) == 0) ? 2'd2 : 2'd1;
            da = {$urandom, $urandom}; dd = {$urandom, $urandom};
         end
         r = 0;
         t = 4'($urandom_range(1, 15));
         case ($urandom_range(0, 9))
            0, 1, 2, 3: r = (owner_of[t] != 0) ? t : 4'd0;
            4:          r = t;
            default:    r = 0;
         endcase
         t = 4'($urandom_range(1, 15));
         rsp = ($urandom_range(0, 3) != 0 && (owner_of[t] == 0 || t == r)) ? t : 4'd0;
         rd = {$urandom, $urandom};
         step(icp, ra, dcp, dc_cmd, da, dd, rsp, r, rd);
         if (last_ic_acc) icp = 0;
         if (last_dc_acc) dcp = 0;
      end

      // Drain whatever is still outstanding.
      for (int k = 1; k < 16; k++)
         if (owner_of[k] != 0) step(0, 0, 0, 0, 0, 0, 0, 4'(k), 64'(k) * 64'h1111);
      idle();
      #2;
      chk("final_inflight", inflight_count, 4'(model_count()));
      chk("final_spur", spurious_tag, spur_m);
      chk("scoreboard_empty", 64'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Processor-side initiator for the unified memory bus. It is the counterpart of the `mem` responder: it drives `proc2mem_*` and consumes `mem2proc_response`, `mem2proc_data` and `mem2proc_tag`.
- Arbitrates between icache (loads only) and dcache (loads and stores) for the single bus.
- Records the tag each accepted load receives, and later routes the returning data to the requester that owns that tag.
- Sits between the cache controllers and the memory port at the top of `pipeline`.

Parameters:
- NUM_TAGS, 15: usable memory tags, 1..15. Tag 0 means "not accepted / no data".
- STARVE_LIMIT, 4: consecutive contested dcache wins after which icache gets priority for one grant.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ic_req_valid  in  1  icache load request
- ic_req_addr  in  64  icache load address
- dc_req_valid  in  1  dcache request
- dc_req_cmd  in  2  BUS_LOAD or BUS_STORE
- dc_req_addr  in  64  dcache address
- dc_req_data  in  64  dcache store data
- mem2proc_response  in  4  accept tag; 0 = rejected
- mem2proc_data  in  64  returning load data
- mem2proc_tag  in  4  tag of returning data; 0 = none
- proc2mem_command  out  2  BUS_NONE/BUS_LOAD/BUS_STORE
- proc2mem_addr  out  64  bus address
- proc2mem_data  out  64  bus store data
- ic_accepted  out  1  icache request taken this cycle
- dc_accepted  out  1  dcache request taken this cycle
- ic_resp_valid  out  1  icache data valid
- dc_resp_valid  out  1  dcache load data valid
- resp_data  out  64  routed `mem2proc_data`
- inflight_count  out  4  outstanding loads
- spurious_tag  out  1  sticky: a tag returned that was not outstanding

Behaviour:
- Reset (asynchronous): clear the tag table, starvation counter, `inflight_count` and `spurious_tag`. While reset is high, force `proc2mem_command`=BUS_NONE, addr/data=0, and all accepted/valid outputs=0.
- Grant (combinational):
  - Dcache wins when both requesters are valid, unless the starvation counter equals STARVE_LIMIT; then icache wins.
  - Only the granted request drives the `proc2mem_*` outputs. BUS_NONE with addr/data 0 when neither is valid.
- Acceptance: `X_accepted` = granted and `mem2proc_response`!=0, in the same cycle. A requester holds its request stable until accepted. Rejection (response 0) costs nothing; the request retries next cycle.
- Starvation counter (registered):
  - Increments when both are valid and dcache is granted.
  - Resets to 0 on any icache grant, or when icache is not requesting.
  - Saturates at STARVE_LIMIT.
- Tag table (registered): one entry per tag holding {valid, owner}.
  - On an accepted BUS_LOAD at posedge: `entry[response]` ← {1, owner}.
  - Accepted BUS_STORE allocates nothing.
- Return path (combinational on table state): when `mem2proc_tag`!=0 and its entry is valid:
  - Assert the owner's `*_resp_valid` for that cycle, with `resp_data`=`mem2proc_data`.
  - Clear the entry at posedge.
- Spurious returns: a `mem2proc_tag` that is nonzero with an invalid entry produces no valid output and sets `spurious_tag` (cleared only by reset).
- Same-cycle return and accept of the same tag: the return is routed to the old owner; the new allocation wins the table write.
- `inflight_count` = number of valid entries. It is registered and updated by +accept −return in the same cycle.
- A `mem2proc_tag` that returns after a reset mid-operation finds its entry invalid: it is dropped and flagged spurious.
- Latency: request-to-acceptance is 0 cycles. Response routing is 0 cycles after `mem2proc_tag` arrives.

Decomposition:
- `sys_defs` holds:
  - BUS_COMMAND enum (BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2)
  - MEM_TAG typedef (logic [3:0])
  - REQ_OWNER enum (OWN_ICACHE, OWN_DCACHE)
  - TAG_ENTRY struct {valid, owner}
  - NUM_MEM_TAGS constant
- Natural sub-module: `mem_tag_table`, which owns allocate, lookup, clear and count. The arbiter top holds grant logic and the starvation counter.

Test Plan:
- Lone icache load to addr 0x100, response=3; eight cycles later tag=3 with data 0xDEAD → `ic_accepted`=1 in the request cycle, `ic_resp_valid`=1 with `resp_data`=0xDEAD, `inflight_count` goes 1→0.
- Both requesters valid for 6 cycles, response always nonzero → dcache is granted 4 times, icache on the 5th, then dcache again.
- Dcache BUS_STORE addr 0x200 data 0x55, response=7 → `dc_accepted`=1, `inflight_count` stays 0. A later `mem2proc_tag`=7 sets `spurious_tag`.
- Tag 5 returns to dcache in the same cycle icache is accepted with response 5 → `dc_resp_valid`=1 that cycle; the next return of tag 5 goes to icache.
- Two loads outstanding (tags 1, 2); reset pulsed mid-cycle → outputs clear immediately, `inflight_count`=0; a later tag 1 return produces no valid output.
- Response=0 for 3 cycles on a dcache load → `dc_accepted`=0 and the command is held; 4th cycle response=9 → accepted, entry 9 = dcache.
